// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven editor for the calendar/time counter.
// Seeds from live time, steps one field at a time, then strobes a load.
module time_set_ctrl #(
    parameter int MAX_DAY     = 30,
    parameter int TIMEOUT_CYC = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [7:0] cur_year,
    input  logic [7:0] cur_month,
    input  logic [7:0] cur_day,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_minute,
    input  logic [7:0] cur_second,
    output logic [7:0] set_year,
    output logic [7:0] set_month,
    output logic [7:0] set_day,
    output logic [7:0] set_hour,
    output logic [7:0] set_minute,
    output logic [7:0] set_second,
    output logic       set_valid,
    output logic       editing,
    output logic [2:0] field_sel
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] DAY_MAX = 8'(MAX_DAY);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_YEAR   = 3'd1;
    localparam logic [2:0] S_MONTH  = 3'd2;
    localparam logic [2:0] S_DAY    = 3'd3;
    localparam logic [2:0] S_HOUR   = 3'd4;
    localparam logic [2:0] S_MIN    = 3'd5;
    localparam logic [2:0] S_SEC    = 3'd6;
    localparam logic [2:0] S_COMMIT = 3'd7;

    function automatic logic [7:0] wrap_step(
        input logic [7:0] v,
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic       up
    );
        logic [7:0] r;
        if (up) r = (v >= hi) ? lo : v + 8'd1;
        else    r = (v <= lo) ? hi : v - 8'd1;
        return r;
    endfunction

    function automatic logic [7:0] clamp(
        input logic [7:0] v,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return (v < lo || v > hi) ? lo : v;
    endfunction

    // Button bits ordered {mode, inc, dec}
    logic [2:0] s1_q, s1_d;
    logic [2:0] s2_q, s2_d;
    logic [2:0] hist_q, hist_d;
    logic [2:0] ev;
    logic       ev_mode, ev_inc, ev_dec, any_ev;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    year_q, year_d;
    logic [7:0]    month_q, month_d;
    logic [7:0]    day_q, day_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic          is_edit;
    logic          timeout;

    always_comb begin
        s1_d    = {btn_mode, btn_inc, btn_dec};
        s2_d    = s1_q;
        hist_d  = s2_q;
        ev      = s2_q & ~hist_q;
        ev_mode = ev[2];
        ev_inc  = ev[1];
        ev_dec  = ev[0];
        any_ev  = |ev;
        is_edit = (state_q != S_IDLE) && (state_q != S_COMMIT);
        timeout = is_edit && (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        // Timeout overrides any event arriving in the same cycle
        if (timeout) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ev_mode) begin
                        year_d  = clamp(cur_year, 8'd0, 8'd99);
                        month_d = clamp(cur_month, 8'd1, 8'd12);
                        day_d   = clamp(cur_day, 8'd1, DAY_MAX);
                        hour_d  = clamp(cur_hour, 8'd0, 8'd23);
                        min_d   = clamp(cur_minute, 8'd0, 8'd59);
                        sec_d   = clamp(cur_second, 8'd0, 8'd59);
                        state_d = S_YEAR;
                    end
                end
                S_COMMIT: state_d = S_IDLE;
                default: begin
                    cnt_d = any_ev ? '0 : cnt_q + CW'(1);
                    if (ev_mode) begin
                        state_d = state_q + 3'd1;
                    end else if (ev_inc ^ ev_dec) begin
                        case (state_q)
                            S_YEAR:  year_d  = wrap_step(year_q, 8'd0, 8'd99, ev_inc);
                            S_MONTH: month_d = wrap_step(month_q, 8'd1, 8'd12, ev_inc);
                            S_DAY:   day_d   = wrap_step(day_q, 8'd1, DAY_MAX, ev_inc);
                            S_HOUR:  hour_d  = wrap_step(hour_q, 8'd0, 8'd23, ev_inc);
                            S_MIN:   min_d   = wrap_step(min_q, 8'd0, 8'd59, ev_inc);
                            S_SEC:   sec_d   = wrap_step(sec_q, 8'd0, 8'd59, ev_inc);
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            hist_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            year_q  <= 8'd0;
            month_q <= 8'd1;
            day_q   <= 8'd1;
            hour_q  <= 8'd0;
            min_q   <= 8'd0;
            sec_q   <= 8'd0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            hist_q  <= hist_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            year_q  <= year_d;
            month_q <= month_d;
            day_q   <= day_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
        end
    end

    assign set_year   = year_q;
    assign set_month  = month_q;
    assign set_day    = day_q;
    assign set_hour   = hour_q;
    assign set_minute = min_q;
    assign set_second = sec_q;
    assign set_valid  = (state_q == S_COMMIT);
    assign editing    = is_edit;
    assign field_sel  = is_edit ? state_q : 3'd0;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a field-array model predicts each
// output change and its cycle; a monitor pops and compares on every change.
module tb_time_set_ctrl;

    localparam int MAX_DAY = 30;
    localparam int TO      = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [7:0] cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second;
    logic [7:0] set_year, set_month, set_day, set_hour, set_minute, set_second;
    logic       set_valid, editing;
    logic [2:0] field_sel;

    time_set_ctrl #(.MAX_DAY(MAX_DAY), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
        .set_valid(set_valid), .editing(editing), .field_sel(field_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] y, mo, d, h, mi, s;
        logic       v, e;
        logic [2:0] fs;
    } out_t;

    typedef struct {
        out_t o;
        int   at;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;

    // Model: fields year..second, visible edit step (0 idle, 1..6 field)
    int f[6];
    int st = 0;
    int lo[6] = '{0, 1, 1, 0, 0, 0};
    int hi[6] = '{99, 12, MAX_DAY, 23, 59, 59};
    int cur[6] = '{0, 0, 0, 0, 0, 0};
    int last_c = 0;

    assign cur_year   = 8'(cur[0]);
    assign cur_month  = 8'(cur[1]);
    assign cur_day    = 8'(cur[2]);
    assign cur_hour   = 8'(cur[3]);
    assign cur_minute = 8'(cur[4]);
    assign cur_second = 8'(cur[5]);

    out_t dut_o;
    assign dut_o = {set_year, set_month, set_day, set_hour, set_minute,
                    set_second, set_valid, editing, field_sel};

    function automatic out_t mk(input int s);
        out_t o;
        o.y  = 8'(f[0]);
        o.mo = 8'(f[1]);
        o.d  = 8'(f[2]);
        o.h  = 8'(f[3]);
        o.mi = 8'(f[4]);
        o.s  = 8'(f[5]);
        o.v  = (s == 7);
        o.e  = (s >= 1 && s <= 6);
        o.fs = o.e ? 3'(s) : 3'd0;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("%0d/%0d/%0d %0d:%0d:%0d v=%0d e=%0d fs=%0d",
                         o.y, o.mo, o.d, o.h, o.mi, o.s, o.v, o.e, o.fs);
    endfunction

    function automatic void push(input out_t o, input int at);
        exp_t e;
        e.o  = o;
        e.at = at;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        f  = '{0, 1, 1, 0, 0, 0};
        st = 0;
    endfunction

    // One button press: high for 3 cycles, low for 3; effect lands 3 edges later
    task automatic press(input bit m, input bit i, input bit d);
        int c;
        int k;
        int n;
        @(negedge clk);
        c = cyc;
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        if (st == 0) begin
            if (m) begin
                for (int j = 0; j < 6; j++)
                    f[j] = (cur[j] < lo[j] || cur[j] > hi[j]) ? lo[j] : cur[j];
                st = 1;
                push(mk(1), c + 3);
            end
        end else if (m) begin
            if (st < 6) begin
                st++;
                push(mk(st), c + 3);
            end else begin
                push(mk(7), c + 3);
                st = 0;
                push(mk(0), c + 4);
            end
        end else if (i != d) begin
            k = st - 1;
            n = hi[k] - lo[k] + 1;
            if (i) f[k] = lo[k] + (f[k] - lo[k] + 1) % n;
            else   f[k] = lo[k] + (f[k] - lo[k] - 1 + n) % n;
            push(mk(st), c + 3);
        end
        last_c = c;
        repeat (3) @(negedge clk);
        btn_mode = 0;
        btn_inc  = 0;
        btn_dec  = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic presses(input int n, input bit m, input bit i, input bit d);
        for (int j = 0; j < n; j++) press(m, i, d);
    endtask

    task automatic check_now(input string name, input out_t want);
        checks++;
        if (dut_o !== want) begin
            errors++;
            $display("FAIL %s: got %s, want %s", name, fmt(dut_o), fmt(want));
        end
    endtask

    // Monitor: every output change must match the next predicted change
    initial begin
        out_t prev;
        out_t now;
        exp_t e;
        wait (mon_en);
        prev = dut_o;
        forever begin
            @(negedge clk);
            now = dut_o;
            if (now !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %s @%0d, want no change",
                             fmt(now), cyc);
                end else begin
                    e = q.pop_front();
                    if (now !== e.o || (e.at >= 0 && e.at != cyc)) begin
                        errors++;
                        $display("FAIL out_change: got %s @%0d, want %s @%0d",
                                 fmt(now), cyc, fmt(e.o), e.at);
                    end
                end
            end
            prev = now;
        end
    end

    initial begin
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check_now("reset_state", mk(0));
        rst = 1'b0;
        mon_en = 1;
        repeat (2) @(negedge clk);

        // Inc/dec in idle are ignored
        press(0, 1, 0);
        press(0, 0, 1);

        // Capture then wrap checks on year, month, day
        cur = '{25, 6, 15, 10, 30, 45};
        press(1, 0, 0);
        cur = '{77, 77, 77, 77, 77, 77};
        presses(26, 0, 0, 1);
        press(0, 1, 0);
        press(1, 0, 0);
        presses(6, 0, 0, 1);
        press(1, 0, 0);
        presses(16, 0, 1, 0);
        presses(4, 1, 0, 0);

        // Full pass with no edits commits the captured values
        cur = '{7, 3, 9, 8, 5, 2};
        presses(7, 1, 0, 0);

        // Out-of-range capture clamps
        cur = '{12, 0, 0, 24, 7, 60};
        presses(7, 1, 0, 0);
        cur = '{200, 13, 31, 255, 60, 99};
        presses(7, 1, 0, 0);

        // Timeout with no presses
        cur = '{50, 5, 5, 5, 5, 5};
        press(1, 0, 0);
        st = 0;
        push(mk(0), last_c + 3 + TO);
        repeat (TO + 6) @(negedge clk);

        // inc+dec is a no-op, mode+inc advances only
        press(1, 0, 0);
        press(0, 1, 1);
        press(1, 1, 0);
        press(0, 1, 0);
        press(1, 0, 1);
        presses(5, 1, 0, 0);

        // Async reset mid-edit in hour field
        cur = '{33, 4, 20, 22, 11, 58};
        presses(4, 1, 0, 0);
        presses(2, 0, 1, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        push(mk(0), -1);
        #1;
        check_now("async_reset", mk(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        presses(7, 1, 0, 0);

        // Randomized sessions
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 6; j++) cur[j] = $urandom_range(0, hi[j] + 4);
            press(0, $urandom_range(0, 1), $urandom_range(0, 1));
            press(1, 0, 0);
            for (int fld = 0; fld < 6; fld++) begin
                for (int j = 0; j < 6; j++) cur[j] = $urandom_range(0, 255);
                for (int p = $urandom_range(0, 5); p > 0; p--) begin
                    r = $urandom_range(0, 3);
                    case (r)
                        0: press(0, 1, 0);
                        1: press(0, 0, 1);
                        2: press(0, 1, 1);
                        default: press(0, 1, 0);
                    endcase
                end
                press(1, $urandom_range(0, 1), $urandom_range(0, 1));
            end
        end

        repeat (10) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d undelivered changes, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Writer side of the calendar/time counter. Turns three debounced user buttons into a field-by-field edit sequence, seeded from the counter's live time.
- Presents the edited time on set_* buses with a one-cycle set_valid load strobe for the counter to capture.
- Drives editing/field_sel so the display path can blink the field being edited.

Parameters:
- MAX_DAY, 30, upper limit of the day field (day range 1..MAX_DAY, same for every month).
- TIMEOUT_CYC, 500000000, idle cycles in any edit state before abandoning the edit (10 s at 50 MHz). Counter width is $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_mode  in  1  debounced level, asynchronous to clk; rising edge enters or advances the edit.
- btn_inc  in  1  debounced level, asynchronous; rising edge increments the selected field.
- btn_dec  in  1  debounced level, asynchronous; rising edge decrements the selected field.
- cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second  in  8 each  live time from the counter, binary.
- set_year, set_month, set_day, set_hour, set_minute, set_second  out  8 each  edit registers, binary, registered.
- set_valid  out  1  one-cycle strobe: the counter loads set_* on this cycle.
- editing  out  1  high in any EDIT_* state.
- field_sel  out  3  0 = none, 1 = year, 2 = month, 3 = day, 4 = hour, 5 = minute, 6 = second.

Behaviour:

Reset (async, rst=1):
- state=IDLE.
- set_year=0, set_month=1, set_day=1, set_hour=0, set_minute=0, set_second=0.
- set_valid=0, editing=0, field_sel=0.
- Synchronizer flops, edge history and timeout counter all 0.
- Reset mid-edit discards the edit; no strobe is issued.

Input conditioning:
- Each button passes through a 2-FF synchronizer plus a history flop. ev_x = sync2 & ~hist.
- A level rising before edge N gives ev_x high between edges N+1 and N+2; the action is visible after edge N+2.
- A held button produces exactly one event.

Event priority, same cycle:
- mode beats inc/dec; inc/dec are dropped.
- inc together with dec is a no-op.

States: IDLE, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.

IDLE:
- inc/dec are ignored.
- On ev_mode, capture all cur_* into set_* and go to EDIT_YEAR.
- Capture clamp: an out-of-range field loads its minimum. Year>99 gives 0; month 0 or >12 gives 1; day 0 or >MAX_DAY gives 1; hour>23, minute>59, second>59 give 0.

EDIT_*:
- ev_inc / ev_dec step the selected field by ±1 with wrap.
- Ranges: year 0..99, month 1..12, day 1..MAX_DAY, hour 0..23, minute 0..59, second 0..59.
- Wrap examples: inc at max goes to min (month 12 to 1); dec at min goes to max (day 1 to MAX_DAY, hour 0 to 23).
- Other fields are untouched.
- ev_mode advances YEAR, MONTH, DAY, HOUR, MIN, SEC, then COMMIT.

COMMIT:
- Lasts exactly one cycle, with set_valid=1 and set_* stable.
- Next state is IDLE.
- set_* hold their value after commit until the next capture.

Timeout:
- The counter clears on any ev_* and on entry to EDIT_YEAR, and counts every cycle in EDIT_*.
- When it reaches TIMEOUT_CYC: go to IDLE, set_valid stays 0, set_* hold their partial values, counter clears.
- An event in the same cycle as the timeout is ignored; timeout wins.

Outputs:
- editing and field_sel are decoded from the registered state; they are valid in the same cycle as the state.
- field_sel=0 in IDLE and COMMIT.

Arithmetic:
- All fields are 8-bit unsigned; range checks are compares on the full 8 bits.
- No BCD.
- cur_* are sampled only on the capture cycle and may change freely otherwise.

Test Plan:
1. Reset, then drive cur = 25/06/15 10:30:45 and pulse btn_mode -> after edge N+2: field_sel=1, editing=1, set_* = 25/6/15/10/30/45.
2. In EDIT_YEAR with year=99, pulse inc -> year=0. Pulse mode, then at month=1 pulse dec -> month=12. Pulse mode, then at day=30 (MAX_DAY=30) pulse inc -> day=1.
3. Full pass: 6 further mode presses with no edits -> exactly one set_valid cycle with set_* = captured values, then IDLE with field_sel=0.
4. Drive cur_month=0, cur_day=0, cur_hour=24, cur_second=60 and enter edit -> set_month=1, set_day=1, set_hour=0, set_second=0.
5. Set TIMEOUT_CYC=20, enter edit, no presses -> IDLE exactly 20 cycles after entry, set_valid never 1. Assert inc+dec together -> no change. Assert mode+inc together -> field advances, value unchanged.
6. In EDIT_HOUR, assert rst for one cycle -> all outputs take their reset values immediately (async); a following btn_mode capture works normally.
